// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one SRAM-like memory port between the instruction fetch port and the
//   data port. Data wins when both request in IDLE. A grant that is driven but
//   not accepted stays locked to that master until mem_addr_ok. Each accepted
//   request's owner is pushed into an in-order ID FIFO, and responses are steered
//   back using the FIFO head.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst_req/inst_addr         instruction read request (word, read-only)
//   inst_addr_ok/data_ok/rdata instruction handshake and response
//   data_req/wr/size/wstrb/addr/wdata  data request
//   data_addr_ok/data_ok/rdata data handshake and response
//   mem_req/wr/size/wstrb/addr/wdata   shared memory request
//   mem_addr_ok                memory accepts mem_req
//   mem_data_ok/mem_rdata      in-order memory response
module sram_req_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             gnt_i, gnt_d;
    logic             full, accept, push, pop, head_id;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [OUTSTANDING-1:0] id_q;     // 0 = inst, 1 = data

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Grant: IDLE picks combinationally (data first); a lock pins the owner.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        case (state)
            IDLE: begin
                if (data_req)      gnt_d = 1'b1;
                else if (inst_req) gnt_i = 1'b1;
            end
            LOCK_I:  gnt_i = 1'b1;
            LOCK_D:  gnt_d = 1'b1;
            default: ;
        endcase
    end

    assign full    = (count == CW'(OUTSTANDING));
    assign mem_req = ~reset & ~full & ((gnt_d & data_req) | (gnt_i & inst_req));
    assign accept  = mem_req & mem_addr_ok;
    assign push    = accept;
    assign pop     = ~reset & mem_data_ok & (count != '0);
    assign head_id = id_q[rd_ptr];

    // Payload is forced to zero in reset so every output reads 0 there.
    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (!reset) begin
            if (gnt_d) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else if (gnt_i) begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
    end

    assign inst_addr_ok = accept & gnt_i;
    assign data_addr_ok = accept & gnt_d;
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop & head_id;
    assign inst_rdata   = reset ? 32'h0 : mem_rdata;
    assign data_rdata   = reset ? 32'h0 : mem_rdata;

    // While full mem_req is low, so neither branch fires and the lock is held.
    always_comb begin
        state_nxt = state;
        if (!full) begin
            if (accept)       state_nxt = IDLE;
            else if (mem_req) state_nxt = gnt_d ? LOCK_D : LOCK_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            id_q   <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                id_q[wr_ptr] <= gnt_d;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    sram_req_arbiter #(.OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 1; inst_req = 1; data_req = 1; data_addr = 32'h55;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hdead;
        #2;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0b exp 0", mem_req); end
        checks++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL rst_addr_ok got %0b%0b exp 00", inst_addr_ok, data_addr_ok); end
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL rst_data_ok got %0b%0b exp 00", inst_data_ok, data_data_ok); end
        checks++; if (mem_addr !== 32'h0 || data_rdata !== 32'h0) begin errors++; $display("FAIL rst_zero_out got addr %0h rdata %0h exp 0", mem_addr, data_rdata); end
        tick();
        checks++; if (dut.count !== 3'd0 || dut.state !== 2'd0) begin errors++; $display("FAIL rst_state got count %0d state %0d exp 0 0", dut.count, dut.state); end
        clear_inputs(); reset = 0;
        tick();
    endtask

    // Simultaneous requests: data first, then inst; responses in accept order.
    task automatic test_priority();
        inst_req = 1; inst_addr = 32'h100;
        data_req = 1; data_wr = 1; data_size = 2'd1; data_wstrb = 4'b0011;
        data_addr = 32'h200; data_wdata = 32'h12345678; mem_addr_ok = 1;
        #2;
        checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL prio_c0_addr_ok got d%0b i%0b exp d1 i0", data_addr_ok, inst_addr_ok); end
        checks++; if (mem_addr !== 32'h200 || mem_wr !== 1'b1 || mem_size !== 2'd1) begin errors++; $display("FAIL prio_d_payload got %0h %0b %0d exp 200 1 1", mem_addr, mem_wr, mem_size); end
        checks++; if (mem_wstrb !== 4'b0011 || mem_wdata !== 32'h12345678) begin errors++; $display("FAIL prio_d_wdata got %0h %0h exp 3 12345678", mem_wstrb, mem_wdata); end
        tick();
        data_req = 0;
        #2;
        checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL prio_c1_addr_ok got i%0b d%0b exp i1 d0", inst_addr_ok, data_addr_ok); end
        checks++; if (mem_addr !== 32'h100 || mem_wr !== 1'b0 || mem_size !== 2'd2 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL prio_i_payload got %0h %0b %0d %0h %0h exp 100 0 2 0 0", mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'haaaa0001;
        #2;
        checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'haaaa0001) begin errors++; $display("FAIL prio_resp0 got d%0b i%0b %0h exp d1 i0 aaaa0001", data_data_ok, inst_data_ok, data_rdata); end
        tick();
        mem_rdata = 32'hbbbb0002;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hbbbb0002) begin errors++; $display("FAIL prio_resp1 got i%0b d%0b %0h exp i1 d0 bbbb0002", inst_data_ok, data_data_ok, inst_rdata); end
        tick();
        clear_inputs();
        #2;
        checks++; if (dut.count !== 3'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL prio_drained got count %0d req %0b exp 0 0", dut.count, mem_req); end
    endtask

    // Unaccepted inst grant locks the port against a later data request.
    task automatic test_lock_inst();
        inst_req = 1; inst_addr = 32'h300;
        #2;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_c0 got req %0b addr %0h aok %0b exp 1 300 0", mem_req, mem_addr, inst_addr_ok); end
        tick();
        data_req = 1; data_addr = 32'h400;
        #2;
        checks++; if (dut.state !== 2'd1 || mem_addr !== 32'h300 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_c1 got state %0d addr %0h daok %0b exp 1 300 0", dut.state, mem_addr, data_addr_ok); end
        tick();
        #2;
        checks++; if (dut.state !== 2'd1 || mem_addr !== 32'h300) begin errors++; $display("FAIL lock_c2 got state %0d addr %0h exp 1 300", dut.state, mem_addr); end
        tick();
        mem_addr_ok = 1;
        #2;
        checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_accept got i%0b d%0b exp i1 d0", inst_addr_ok, data_addr_ok); end
        tick();
        inst_req = 0;
        #2;
        checks++; if (dut.state !== 2'd0 || data_addr_ok !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("FAIL lock_then_d got state %0d daok %0b addr %0h exp 0 1 400", dut.state, data_addr_ok, mem_addr); end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL lock_resp0 got i%0b d%0b exp i1 d0", inst_data_ok, data_data_ok); end
        tick();
        #2;
        checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL lock_resp1 got d%0b i%0b exp d1 i0", data_data_ok, inst_data_ok); end
        tick();
        clear_inputs();
    endtask

    // Unaccepted data grant locks the port too.
    task automatic test_lock_data();
        data_req = 1; data_addr = 32'h500; inst_req = 1; inst_addr = 32'h600;
        tick();
        #2;
        checks++; if (dut.state !== 2'd2 || mem_addr !== 32'h500) begin errors++; $display("FAIL lockd_hold got state %0d addr %0h exp 2 500", dut.state, mem_addr); end
        mem_addr_ok = 1;
        #2;
        checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL lockd_accept got d%0b i%0b exp d1 i0", data_addr_ok, inst_addr_ok); end
        tick();
        data_req = 0;
        #2;
        checks++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h600) begin errors++; $display("FAIL lockd_inst got %0b %0h exp 1 600", inst_addr_ok, mem_addr); end
        tick();
        clear_inputs(); mem_data_ok = 1;
        #2;
        checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL lockd_resp0 got %0b exp 1", data_data_ok); end
        tick();
        #2;
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL lockd_resp1 got %0b exp 1", inst_data_ok); end
        tick();
        clear_inputs();
    endtask

    // Fill the ID FIFO, then free one slot with a response.
    task automatic test_full();
        inst_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            inst_addr = 32'h1000 + 32'(4 * i);
            #2;
            checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_fill%0d got %0b exp 1", i, inst_addr_ok); end
            tick();
        end
        #2;
        checks++; if (dut.count !== 3'd4 || mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL full_block got count %0d req %0b aok %0b exp 4 0 0", dut.count, mem_req, inst_addr_ok); end
        mem_data_ok = 1;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL full_pop got dok %0b req %0b exp 1 0", inst_data_ok, mem_req); end
        tick();
        mem_data_ok = 0;
        #2;
        checks++; if (dut.count !== 3'd3 || mem_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_reopen got count %0d req %0b aok %0b exp 3 1 1", dut.count, mem_req, inst_addr_ok); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL full_drain%0d got i%0b d%0b exp i1 d0", i, inst_data_ok, data_data_ok); end
            tick();
        end
        clear_inputs();
        #2;
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", dut.count); end
    endtask

    // Push and pop in one cycle at count 2; IDs stay in order across wrap.
    task automatic test_back_to_back();
        mem_addr_ok = 1; data_req = 1;
        #2;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_c0 got %0b exp 1", data_addr_ok); end
        tick();
        data_req = 0; inst_req = 1;
        #2;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_c1 got %0b exp 1", inst_addr_ok); end
        tick();
        inst_req = 0; data_req = 1; mem_data_ok = 1;
        #2;
        checks++; if (data_addr_ok !== 1'b1 || data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_c2 got aok %0b d%0b i%0b exp 1 1 0", data_addr_ok, data_data_ok, inst_data_ok); end
        tick();
        checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL b2b_cnt2 got %0d exp 2", dut.count); end
        data_req = 0; inst_req = 1;
        #2;
        checks++; if (inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_c3 got aok %0b i%0b d%0b exp 1 1 0", inst_addr_ok, inst_data_ok, data_data_ok); end
        tick();
        checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL b2b_cnt3 got %0d exp 2", dut.count); end
        inst_req = 0; data_req = 1;
        #2;
        checks++; if (data_addr_ok !== 1'b1 || data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_c4 got aok %0b d%0b i%0b exp 1 1 0", data_addr_ok, data_data_ok, inst_data_ok); end
        tick();
        checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL b2b_cnt4 got %0d exp 2", dut.count); end
        data_req = 0; mem_addr_ok = 0;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_c5 got i%0b d%0b exp i1 d0", inst_data_ok, data_data_ok); end
        tick();
        #2;
        checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_c6 got d%0b i%0b exp d1 i0", data_data_ok, inst_data_ok); end
        tick();
        clear_inputs();
        #2;
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", dut.count); end
    endtask

    task automatic test_stray_resp();
        mem_data_ok = 1; mem_rdata = 32'h77;
        #2;
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL stray_dok got i%0b d%0b exp 0 0", inst_data_ok, data_data_ok); end
        tick();
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL stray_cnt got %0d exp 0", dut.count); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        inst_req = 1; inst_addr = 32'h2000; mem_addr_ok = 1;
        tick();
        tick();
        checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL rmid_pre got %0d exp 2", dut.count); end
        reset = 1;
        #2;
        checks++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL rmid_in_reset got req %0b aok %0b exp 0 0", mem_req, inst_addr_ok); end
        tick();
        reset = 0; clear_inputs();
        #2;
        checks++; if (dut.count !== 3'd0 || dut.state !== 2'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL rmid_post got count %0d state %0d req %0b exp 0 0 0", dut.count, dut.state, mem_req); end
        mem_data_ok = 1;
        #2;
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL rmid_late got i%0b d%0b exp 0 0", inst_data_ok, data_data_ok); end
        tick();
        clear_inputs();
        #2;
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", dut.count); end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick();
        tick();
        test_reset();
        test_priority();
        test_lock_inst();
        test_lock_data();
        test_full();
        test_back_to_back();
        test_stray_resp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
